clk_ctrl: RTL
=============

# clk_ctrl

Run/halt/single-step controller for the processor core clock domain. Runs on the free-running `clk` from the clock generator and produces a clock-enable strobe `core_ce` that gates every state-holding element of the core. Supports a programmable divide ratio, an N-cycle step mode, an external halt request and a free-running count of issued enables. It sits in the Control Unit, between the clock generator and the core/debug logic.

## Interface

Parameters:
- `CNT_W`, default 64: width of the issued-enable counter `cycles`.
- `STEP_W`, default 16: width of the step count `cmd_arg`.
- `DIV_W`, default 4: width of the divide ratio `div`.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accept. A transfer occurs at a rising edge where `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  command code: 00 HALT, 01 RUN, 10 STEP, 11 CLR.
- `cmd_arg`  in  STEP_W  number of steps for STEP; ignored for other ops.
- `div`  in  DIV_W  divide ratio. Sampled into `div_q` on acceptance of RUN or STEP.
- `halt_req`  in  1  external halt, for example from ebreak or the debugger. It is level-sensitive and has highest priority.
- `core_ce`  out  1  core clock enable, combinational from registered state.
- `state`  out  2  current state: 00 HALTED, 01 RUN, 10 STEP.
- `done`  out  1  one-cycle pulse when a STEP sequence completes.
- `cycles`  out  CNT_W  number of `core_ce` pulses issued, modulo 2^CNT_W.

## Operation

Reset values:
- `state` = HALTED, `div_q` = 0, `div_cnt` = 0, `step_left` = 0.
- `cycles` = 0, `done` = 0, `core_ce` = 0.
- `cmd_ready` = 1 (provided `halt_req` is low).

Command acceptance:
- `cmd_ready` = (`state` != STEP) && !`halt_req`.

Clock enable:
- `core_ce` = (`state` != HALTED) && (`div_cnt` == `div_q`) && !`halt_req`.
- `div_cnt` increments every cycle while `state` != HALTED and wraps to 0 when it equals `div_q`.
- `div_cnt` is cleared on entry to RUN or STEP and while HALTED.

State machine:
- **HALTED**
  - RUN accepted: latch `div_q` <= `div`, go to RUN.
  - STEP accepted with `cmd_arg` != 0: latch `div_q`, set `step_left` <= `cmd_arg`, go to STEP.
  - STEP accepted with `cmd_arg` == 0: stay HALTED, pulse `done` next cycle, issue no `core_ce`.
  - HALT accepted: no-op.
- **RUN**
  - HALT accepted: go to HALTED next cycle. A `core_ce` in the acceptance cycle is still issued.
  - RUN accepted: re-latch `div_q` and restart `div_cnt` at 0.
  - STEP: accepted and ignored; stays in RUN.
- **STEP**
  - Each `core_ce` decrements `step_left`.
  - `core_ce` with `step_left` == 1: go to HALTED and pulse `done` in the following cycle.
  - No commands are accepted in this state.
- **Any state, `halt_req` high**
  - Sampled at an edge: `state` <= HALTED.
  - In the same cycle, `core_ce` is forced low and the cycle is not counted.
  - A STEP aborted this way does not pulse `done`; `step_left` is cleared.

Counter:
- `cycles` increments by 1 on each cycle where `core_ce` is high, wrapping to 0 after 2^CNT_W − 1.
- CLR accepted in any state: `cycles` <= 0. If `core_ce` is high in the same cycle, the clear wins and the result is 0, not 1.

Reset mid-operation aborts everything: all registers return to their reset values at that edge with no `done` pulse. Because reset is synchronous, `core_ce` in the reset cycle follows the pre-reset state; reset takes effect from the next cycle.

## Timing

- Command accepted at edge N: new state is visible from cycle N+1.
- First `core_ce` after RUN or STEP acceptance: cycle N+1+`div_q`.
- `core_ce` period: `div_q`+1 cycles, giving a duty of one cycle high.
- STEP of k steps: the last `core_ce` is at cycle N+1+k·(`div_q`+1)−1. `done` is high in the next cycle and `state` reads HALTED in that same cycle.
- `halt_req` acts combinationally on `core_ce` (zero latency) and registered on `state` (one cycle).
- `cycles` is registered: it reflects a `core_ce` one cycle later.

## Configuration

- `CLK_CTRL_CYCLE_CNT_EN` defined: the `cycles` counter is implemented as described.
- Not defined:
  - `cycles` is tied to 0 and no counter flops are synthesized.
  - CLR is still accepted but is a no-op.
  - All other behaviour is identical.

## Test plan

- **Reset, then idle:** `reset` high for 2 cycles, then idle 10 cycles → `state`=0, `core_ce`=0, `cycles`=0, `cmd_ready`=1 throughout.
- **RUN, div=0, then HALT:** RUN with `div`=0 for 20 cycles, then HALT → `core_ce` high in 20 consecutive cycles starting the cycle after acceptance (the HALT acceptance cycle is the 20th); `cycles`=20 after HALT settles; `state`=0.
- **STEP, div=2:** STEP with `cmd_arg`=3, `div`=2 → `core_ce` pulses at cycles N+3, N+6, N+9; `done` at N+10; `cmd_ready` low during N+1..N+9; `cycles`=3.
- **halt_req mid-RUN:** during RUN with `div`=1, assert `halt_req` in a `core_ce`-high cycle → `core_ce` low in that cycle, `state`=0 the next cycle, count not incremented; RUN offered while `halt_req` is high is not accepted.
- **CLR vs enable, and wrap:** CLR in a RUN cycle with `core_ce` high → `cycles`=0 next cycle. With `CNT_W`=4, 17 enables → `cycles`=1.
- **Zero-length STEP and reset mid-STEP:** STEP with `cmd_arg`=0 → `done` pulses one cycle, no `core_ce`. A STEP of 5 interrupted by `reset` after 2 pulses → `done` never pulses, all outputs at reset values.

Source files
------------

// File: rtl/clk_ctrl.sv
// Core clock-enable controller: run / halt / N-step with a programmable divider.
// Build option: define CLK_CTRL_CYCLE_CNT_EN to implement the issued-enable counter `cycles`.
// When it is left undefined, `cycles` reads 0, no counter flops exist and CLR is a no-op.
module clk_ctrl #(
    parameter int unsigned CNT_W  = 64,
    parameter int unsigned STEP_W = 16,
    parameter int unsigned DIV_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic [DIV_W-1:0]  div,
    input  logic              halt_req,
    output logic              core_ce,
    output logic [1:0]        state,
    output logic              done,
    output logic [CNT_W-1:0]  cycles
);

    typedef enum logic [1:0] {
        StHalted = 2'b00,
        StRun    = 2'b01,
        StStep   = 2'b10
    } state_e;

    localparam logic [1:0] OpHalt = 2'b00;
    localparam logic [1:0] OpRun  = 2'b01;
    localparam logic [1:0] OpStep = 2'b10;
    localparam logic [1:0] OpClr  = 2'b11;

    state_e             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [STEP_W-1:0]  step_left_q;
    logic               done_q;
    logic               cmd_acc;

    // Handshake and enable are combinational from registered state; halt_req masks both at once.
    always_comb begin
        cmd_ready = (state_q != StStep) && !halt_req;
        cmd_acc   = cmd_valid && cmd_ready;
        core_ce   = (state_q != StHalted) && (div_cnt_q == div_q) && !halt_req;
    end

    assign state = state_q;
    assign done  = done_q;

    // Run/halt/step state machine with divider phase and remaining-step count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StHalted;
            div_q       <= '0;
            div_cnt_q   <= '0;
            step_left_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Free-running divider phase; held at 0 while halted.
            if (state_q != StHalted) begin
                div_cnt_q <= (div_cnt_q == div_q) ? '0 : div_cnt_q + DIV_W'(1);
            end else begin
                div_cnt_q <= '0;
            end

            if (halt_req) begin
                // Abort without a done pulse; leftover steps are discarded.
                state_q     <= StHalted;
                step_left_q <= '0;
                div_cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    StHalted: begin
                        if (cmd_acc && cmd_op == OpRun) begin
                            div_q     <= div;
                            div_cnt_q <= '0;
                            state_q   <= StRun;
                        end else if (cmd_acc && cmd_op == OpStep) begin
                            if (cmd_arg != '0) begin
                                div_q       <= div;
                                div_cnt_q   <= '0;
                                step_left_q <= cmd_arg;
                                state_q     <= StStep;
                            end else begin
                                // Zero-length step completes immediately.
                                done_q <= 1'b1;
                            end
                        end
                    end
                    StRun: begin
                        if (cmd_acc && cmd_op == OpHalt) begin
                            state_q <= StHalted;
                        end else if (cmd_acc && cmd_op == OpRun) begin
                            div_q     <= div;
                            div_cnt_q <= '0;
                        end
                    end
                    StStep: begin
                        if (core_ce) begin
                            step_left_q <= step_left_q - STEP_W'(1);
                            if (step_left_q == STEP_W'(1)) begin
                                state_q <= StHalted;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= StHalted;
                endcase
            end
        end
    end

`ifdef CLK_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycles_q;

    // Issued-enable counter; a CLR in the same cycle as an enable wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q <= '0;
        end else if (cmd_acc && cmd_op == OpClr) begin
            cycles_q <= '0;
        end else if (core_ce) begin
            cycles_q <= cycles_q + CNT_W'(1);
        end
    end

    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif

endmodule
